rand_lfsr_bank: RTL and testbench
=================================

# rand_lfsr_bank

Parametrised multi-channel pseudo-random word generator, successor to the single-channel generators in the random library. NCH independent Galois LFSR channels are seeded from one seed bus and advanced WS-bit-steps at a time behind a valid/ready handshake. The block adds seed-derived per-channel decorrelation, warm-up discard, zero-state protection and back-pressure. It sits between the seed source (e.g. rand_adc / rand_clk entropy words) and consumers such as noise injectors or test-pattern generators.

## Interface
- WS, 16: word width per channel (≥4).
- NCH, 4: number of channels (≥1).
- POLY, 16'hB400: Galois feedback mask, WS bits.
- STEP, WS: LFSR shifts per advance (1..WS); unrolled combinationally.
- WARMUP, 8: advances discarded after each load (0 allowed).
- SEED_SALT, 16'h9E37: per-channel seed perturbation, WS bits.
- iCLK  in  1  clock; all logic on rising edge.
- iRST_N  in  1  reset, synchronous, active-low.
- iSeed  in  WS  seed word, sampled when iLoad=1.
- iLoad  in  1  single-cycle seed strobe.
- oOut  out  NCH*WS  channel c at bits [c*WS +: WS].
- oValid  out  1  oOut holds a fresh word set.
- iReady  in  1  consumer accepts oOut when oValid=1.
- oBusy  out  1  high during WARMUP.

## Operation
- FSM states: IDLE (unseeded), WARMUP, RUN.
- Reset: FSM→IDLE, all channel states 0, warm-up counter 0, oValid 0, oBusy 0, oOut 0.
- Seed derivation: s_c = iSeed ^ (c*SEED_SALT mod 2^WS); if s_c==0, s_c = 1. Channel 0 therefore equals iSeed unless zero.
- Single shift: lsb = s[0]; s = s>>1; if lsb, s ^= POLY. One advance = STEP shifts.
- IDLE: iLoad → states←s_c; WARMUP if WARMUP>0 (counter←WARMUP), else RUN. Otherwise hold.
- WARMUP: every cycle all channels advance once, counter decrements; counter reaching 1 → RUN next. oValid 0, oBusy 1.
- RUN: oValid 1; oOut = current states. oValid&&iReady → all channels advance once. No handshake → states held stable.
- iLoad in any state (WARMUP, RUN) restarts exactly as from IDLE; load beats a same-cycle handshake (no advance of old state, no word counted).
- Zero-state guard: if an advance result for any channel is 0 (only possible with non-primitive POLY), that channel is loaded with 1 instead.
- oOut is forced to 0 whenever oValid=0.

## Timing
- iLoad sampled at edge t → WARMUP=0: oValid=1 from t+1, first word = derived seeds. WARMUP=N: oBusy=1 for cycles t+1..t+N, oValid=1 from t+1+N.
- Throughput: one word set per cycle with iReady held high.
- Handshake: new word visible the cycle after the accepting edge; oValid never drops in RUN except via reset.
- Reset mid-WARMUP or mid-RUN: next cycle back in IDLE with all outputs 0.
- All outputs registered except the optional tempering XOR.

## Configuration
- RAND_TEMPER_EN defined: oOut per channel = s ^ (s >> (WS/2)) (combinational output tempering); internal state unaffected.
- Undefined: oOut per channel = raw state s.
- Forced-zero rule when oValid=0 applies in both cases.

## Structure
- Package rand_pkg: FSM state enum (IDLE/WARMUP/RUN), default POLY constants for WS=16/32, default SEED_SALT, lfsr_step function.
- Sub-module rand_lfsr_core: one channel (state register, STEP-unrolled advance, zero guard, seed load); rand_lfsr_bank instantiates NCH of them under a shared FSM and warm-up counter.

## Test plan
- Reset, then no iLoad for 20 cycles → oValid=0, oBusy=0, oOut=0 throughout.
- WS=16, STEP=1, WARMUP=0, NCH=1, iSeed=0x0000 pulse, iReady=1 → words 0x0001, 0xB400, 0x5A00 on consecutive cycles.
- Same with RAND_TEMPER_EN → 0x0001, 0xB4B4, 0x5A5A.
- WARMUP=8, iLoad → oBusy high exactly 8 cycles, oValid rises on cycle 9; iReady=0 for 5 cycles → oOut unchanged.
- iLoad asserted in RUN together with iReady=1 → next oOut equals derived seeds (channel 1 = iSeed^0x9E37), no advance.
- iRST_N low for one cycle during WARMUP → IDLE next cycle, outputs 0; subsequent iLoad behaves as first load.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and helpers for the multi-channel LFSR word generator.
package rand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    localparam logic [15:0] POLY16      = 16'hB400;
    localparam logic [31:0] POLY32      = 32'h8020_0003;
    localparam logic [15:0] SALT16      = 16'h9E37;
    localparam int          LFSR_MAXW   = 64;

    // One Galois shift on a zero-extended state; any word width up to 64 fits.
    function automatic logic [LFSR_MAXW-1:0] lfsr_step(input logic [LFSR_MAXW-1:0] s,
                                                      input logic [LFSR_MAXW-1:0] poly);
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

endpackage

// File: rtl/rand_lfsr_core.sv
// One LFSR channel: state register, STEP-unrolled advance, zero guard and seed load.
module rand_lfsr_core
    import rand_pkg::*;
#(
    parameter int            WS   = 16,
    parameter logic [WS-1:0] POLY = WS'(POLY16),
    parameter int            STEP = WS
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [WS-1:0] seed_i,
    input  logic          adv_i,
    output logic [WS-1:0] state_o
);

    logic [WS-1:0]        state_q, state_d;
    logic [LFSR_MAXW-1:0] walk;
    logic [WS-1:0]        advVal;

    // The whole walk is compared against zero; its upper bits never leave zero.
    always_comb begin
        walk = LFSR_MAXW'(state_q);
        for (int i = 0; i < STEP; i++) begin
            walk = lfsr_step(walk, LFSR_MAXW'(POLY));
        end
        advVal = walk[WS-1:0];
        if (walk == '0) begin
            advVal = WS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? WS'(1) : seed_i;
        end else if (adv_i) begin
            state_d = advVal;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rand_lfsr_bank.sv
// NCH seeded Galois LFSR channels behind a shared warm-up/run FSM and valid/ready handshake.
// Optional output tempering is enabled by defining RAND_TEMPER_EN.
module rand_lfsr_bank
    import rand_pkg::*;
#(
    parameter int            WS        = 16,
    parameter int            NCH       = 4,
    parameter logic [WS-1:0] POLY      = WS'(POLY16),
    parameter int            STEP      = WS,
    parameter int            WARMUP    = 8,
    parameter logic [WS-1:0] SEED_SALT = WS'(SALT16)
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [WS-1:0]     iSeed,
    input  logic              iLoad,
    output logic [NCH*WS-1:0] oOut,
    output logic              oValid,
    input  logic              iReady,
    output logic              oBusy
);

    localparam int CW = $clog2(WARMUP + 2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, busy_q;
    logic          load, adv;
    logic [WS-1:0] chan [NCH];

    // A load wins over everything, including a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        adv     = 1'b0;
        if (iLoad) begin
            load = 1'b1;
            if (WARMUP > 0) begin
                state_d = ST_WARMUP;
                cnt_d   = CW'(WARMUP);
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    adv   = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:  adv = valid_q && iReady;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == ST_RUN);
            busy_q  <= (state_d == ST_WARMUP);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [63:0] SALT_PROD = 64'(c) * 64'(SEED_SALT);
        localparam logic [WS-1:0] SALT_C  = SALT_PROD[WS-1:0];

        rand_lfsr_core #(
            .WS   (WS),
            .POLY (POLY),
            .STEP (STEP)
        ) u_core (
            .clk_i   (iCLK),
            .rst_ni  (iRST_N),
            .load_i  (load),
            .seed_i  (iSeed ^ SALT_C),
            .adv_i   (adv),
            .state_o (chan[c])
        );

`ifdef RAND_TEMPER_EN
        assign oOut[c*WS +: WS] = valid_q ? (chan[c] ^ (chan[c] >> (WS/2))) : '0;
`else
        assign oOut[c*WS +: WS] = valid_q ? chan[c] : '0;
`endif
    end

    assign oValid = valid_q;
    assign oBusy  = busy_q;

endmodule

// File: tb/tb_rand_lfsr_bank.sv
// Bench for rand_lfsr_bank: two configurations checked against a word-level reference model.
module tb_rand_lfsr_bank;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [15:0] iSeed;
    logic        iLoad;
    logic        iReady;

    logic [31:0] outA;
    logic        validA, busyA;
    logic [63:0] outB;
    logic        validB, busyB;

    int errors = 0;
    int checks = 0;

    // Model configuration: index 0 = NCH 2/STEP 1/WARMUP 0, index 1 = NCH 4/STEP 16/WARMUP 8.
    int          nchOf  [2] = '{2, 4};
    int          stepOf [2] = '{1, 16};
    int          warmOf [2] = '{0, 8};
    int unsigned mS     [2][4];
    bit          mSeeded[2];
    int          mWarm  [2];

    always #5 iCLK = ~iCLK;

    rand_lfsr_bank #(.WS(16), .NCH(2), .POLY(16'hB400), .STEP(1), .WARMUP(0),
                     .SEED_SALT(16'h9E37)) dutA (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSeed(iSeed), .iLoad(iLoad),
        .oOut(outA), .oValid(validA), .iReady(iReady), .oBusy(busyA));

    rand_lfsr_bank #(.WS(16), .NCH(4), .POLY(16'hB400), .STEP(16), .WARMUP(8),
                     .SEED_SALT(16'h9E37)) dutB (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSeed(iSeed), .iLoad(iLoad),
        .oOut(outB), .oValid(validB), .iReady(iReady), .oBusy(busyB));

    function automatic int unsigned advanceWord(int unsigned s, int steps);
        for (int i = 0; i < steps; i++) begin
            s = (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
        end
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int unsigned temper(int unsigned s);
`ifdef RAND_TEMPER_EN
        return s ^ (s / 256);
`else
        return s;
`endif
    endfunction

    function automatic int unsigned deriveSeed(int unsigned seed, int c);
        int unsigned s;
        s = (seed ^ ((c * 32'h9E37) % 65536)) % 65536;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic logic [63:0] expOut(int k);
        logic [63:0] r;
        r = '0;
        if (mSeeded[k] && mWarm[k] == 0) begin
            for (int c = 0; c < nchOf[k]; c++) begin
                r[c*16 +: 16] = 16'(temper(mS[k][c]));
            end
        end
        return r;
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (!iRST_N) begin
                mSeeded[k] = 1'b0;
                mWarm[k]   = 0;
                for (int c = 0; c < 4; c++) mS[k][c] = 0;
            end else if (iLoad) begin
                mSeeded[k] = 1'b1;
                mWarm[k]   = warmOf[k];
                for (int c = 0; c < nchOf[k]; c++) mS[k][c] = deriveSeed(iSeed, c);
            end else if (mSeeded[k] && (mWarm[k] > 0 || iReady)) begin
                if (mWarm[k] > 0) mWarm[k]--;
                for (int c = 0; c < nchOf[k]; c++) mS[k][c] = advanceWord(mS[k][c], stepOf[k]);
            end
        end
    endtask

    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model and DUTs see the same edge, outputs sampled 1 ns later.
    task automatic applyStimulus();
        @(posedge iCLK);
        modelEdge();
        #1;
        checkOutput("A.valid", 64'(validA), 64'(mSeeded[0] && mWarm[0] == 0));
        checkOutput("A.busy",  64'(busyA),  64'(mSeeded[0] && mWarm[0] > 0));
        checkOutput("A.out",   64'(outA),   expOut(0));
        checkOutput("B.valid", 64'(validB), 64'(mSeeded[1] && mWarm[1] == 0));
        checkOutput("B.busy",  64'(busyB),  64'(mSeeded[1] && mWarm[1] > 0));
        checkOutput("B.out",   outB,        expOut(1));
    endtask

    initial begin
        logic [15:0] wordsA [3];
        logic [63:0] hold;
        logic [15:0] s;
        int          busyCnt, firstValid;

`ifdef RAND_TEMPER_EN
        wordsA = '{16'h0001, 16'hB4B4, 16'h5A5A};
`else
        wordsA = '{16'h0001, 16'hB400, 16'h5A00};
`endif
        $display("[TB] start");
        iRST_N = 1'b0; iLoad = 1'b0; iReady = 1'b0; iSeed = '0;
        repeat (2) applyStimulus();
        iRST_N = 1'b1;

        for (int i = 0; i < 20; i++) begin
            iReady = 1'($urandom_range(0, 1));
            applyStimulus();
            checkOutput("idle.zero", {outB[31:0], outA} | 64'(validA | validB | busyA | busyB), 64'd0);
        end

        iSeed = 16'h0000; iReady = 1'b1; iLoad = 1'b1;
        busyCnt = 0; firstValid = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
            iLoad = 1'b0;
            if (i <= 3) checkOutput("A.seed0.word", 64'(outA[15:0]), 64'(wordsA[i-1]));
            if (busyB) busyCnt++;
            if (validB && firstValid == 0) firstValid = i;
        end
        checkOutput("B.busy.len", 64'(busyCnt), 64'd8);
        checkOutput("B.valid.first", 64'(firstValid), 64'd9);

        iReady = 1'b0;
        hold = outB;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("B.stall.hold", outB, hold);
        end

        for (int i = 0; i < 200; i++) begin
            iReady = 1'($urandom_range(0, 1));
            iLoad  = ($urandom_range(0, 15) == 0);
            iSeed  = 16'($urandom);
            applyStimulus();
        end

        iLoad = 1'b0; iReady = 1'b1;
        repeat (12) applyStimulus();
        s = 16'($urandom_range(1, 65535));
        if (s == 16'h9E37) s = 16'h1234;
        iSeed = s; iLoad = 1'b1;
        applyStimulus();
        iLoad = 1'b0;
        checkOutput("A.reload.ch0", 64'(outA[15:0]),  64'(temper(s)));
        checkOutput("A.reload.ch1", 64'(outA[31:16]), 64'(temper(s ^ 16'h9E37)));

        iSeed = 16'hACE1; iLoad = 1'b1;
        applyStimulus();
        iLoad = 1'b0;
        repeat (3) applyStimulus();
        iRST_N = 1'b0;
        applyStimulus();
        checkOutput("B.rst.out", outB | 64'(validB | busyB), 64'd0);
        iRST_N = 1'b1;
        repeat (3) applyStimulus();

        iLoad = 1'b1;
        busyCnt = 0; firstValid = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
            iLoad = 1'b0;
            if (busyB) busyCnt++;
            if (validB && firstValid == 0) firstValid = i;
        end
        checkOutput("B.rst.busy.len", 64'(busyCnt), 64'd8);
        checkOutput("B.rst.valid.first", 64'(firstValid), 64'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
